seq_subtractor: RTL and testbench
=================================

Name: seq_subtractor

Overview:
- Multi-cycle, digit-serial subtractor; computes diff = a - b - b_in on WIDTH-bit operands, DIGIT bits per cycle, LSB slice first.
- Borrow carried slice to slice through a register; replaces a wide ripple borrow chain for wide operands.
- Sits between operand producer and result consumer; valid/ready handshake on both sides.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
b_in  input  1  borrow in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - b_in, modulo 2^WIDTH
b_out  output  1  final borrow; 1 when a < b + b_in (unsigned)
zero  output  1  diff == 0

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- NSLICE = WIDTH/DIGIT. Slice counter width = clog2(NSLICE), min 1.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid && in_ready: latch a, b into shift registers, latch b_in into borrow register, clear slice count and result register, go to RUN.
- RUN: in_ready=0. Each cycle: {br, d} = a[DIGIT-1:0] - b[DIGIT-1:0] - borrow, computed DIGIT+1 bits wide; br = 1 when the slice underflows. Store d into result slice at index count (slice 0 = LSBs). borrow <= br. Shift a, b right by DIGIT. count++.
- After slice NSLICE-1 is processed, go to DONE. Latency: accept edge to out_valid high = NSLICE cycles.
- DONE: out_valid=1; diff, b_out, zero stable while out_valid=1. On out_ready, go to IDLE; out_valid drops next cycle.
- No overlap. A new operand is accepted only in IDLE. in_ready and out_valid are never both 1.
- out_ready high before DONE has no effect. in_valid outside IDLE is ignored, not queued.
- b_out = borrow register after the last slice. zero is computed from the final diff.
- Boundary cases:
  - b_in=1 with a==b gives diff all-ones, b_out=1.
  - a=0, b=all-ones, b_in=1 gives diff=0, b_out=1, zero=1.
  - DIGIT==WIDTH gives NSLICE=1, so latency is 1 cycle.
- Reset values:
  - State IDLE; in_ready=1 from the first cycle after reset.
  - out_valid=0, diff=0, b_out=0, zero=0.
  - Internal borrow, count and shift registers = 0.
- Reset mid-RUN or mid-DONE aborts the operation. The result is discarded and never presented.
- Holding rst with in_valid=1 accepts nothing.

Optional Feature:
- Macro SEQ_SUB_SAT_EN.
- Defined: unsigned saturating subtract. When the final borrow = 1, diff is forced to 0 and zero = 1. b_out still reports 1, so underflow stays visible. Latency unchanged.
- Undefined: modulo-2^WIDTH result as specified above. No extra logic.

Test Plan:
- Reset, then a=0x1234, b=0x0234, b_in=0, one handshake (WIDTH=16, DIGIT=4). Required: out_valid rises exactly 4 cycles after accept; diff=0x1000, b_out=0, zero=0.
- a=0x0000, b=0x0001, b_in=0. Required: diff=0xFFFF, b_out=1; with SEQ_SUB_SAT_EN, diff=0x0000, zero=1, b_out=1.
- a=0x0005, b=0x0005, b_in=1, then a=0x0005, b=0x0005, b_in=0. Required: first diff=0xFFFF, b_out=1; second diff=0x0000, zero=1, b_out=0. Borrow crosses all 4 slices.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands. Required: diff, b_out, zero stable; in_ready=0 throughout. After out_ready=1, back to IDLE and the next operand is accepted.
- Assert rst for 1 cycle during cycle 2 of RUN. Required: out_valid never rises for that operand; next cycle all outputs at reset values, in_ready=1. A following 0x8000-0x0001 gives 0x7FFF, b_out=0.
- Parameter sweep DIGIT=1 and DIGIT=16 at WIDTH=16, plus WIDTH=32/DIGIT=8, with 1000 random operands each. Required: latency = NSLICE; diff and b_out match the behavioural model {b_out,diff} = a - b - b_in.

Source files
------------

// File: rtl/seq_subtractor_if.sv
// Operand/result handshake bundle for seq_subtractor.
// The producer/consumer side uses the master modport; the subtractor uses the slave modport.
interface seq_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             b_out;
   logic             zero;

   modport master (
      output in_valid, a, b, b_in, out_ready,
      input  in_ready, out_valid, diff, b_out, zero
   );

   modport slave (
      input  in_valid, a, b, b_in, out_ready,
      output in_ready, out_valid, diff, b_out, zero
   );
endinterface

// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: diff = a - b - b_in, DIGIT bits per cycle, LSB slice first.
// Optional macro SEQ_SUB_SAT_EN selects unsigned saturation (diff forced to 0 on underflow).
module seq_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic          clk,
   input logic          rst,
   seq_subtractor_if.slave io
);
   localparam int NSLICE = WIDTH / DIGIT;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt, diff_q;
   logic             borrow, b_out_q, zero_q;
   logic [CW-1:0]    count;
   logic [DIGIT-1:0] d;
   logic             br;
   logic             accept, last_slice;

   assign accept     = (state == IDLE) && io.in_valid;
   assign last_slice = (count == CW'(NSLICE - 1));

   // One slice of the borrow chain, plus the result word with this slice merged in.
   always_comb begin
      {br, d} = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
      res_nxt = res;
      res_nxt[DIGIT*int'(count) +: DIGIT] = d;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      case (state)
         IDLE: begin
            io.in_ready = 1'b1;
            if (io.in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last_slice) state_nxt = DONE;
         end
         DONE: begin
            io.out_valid = 1'b1;
            if (io.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res     <= '0;
         borrow  <= 1'b0;
         count   <= '0;
         diff_q  <= '0;
         b_out_q <= 1'b0;
         zero_q  <= 1'b0;
      end else if (accept) begin
         a_sh   <= io.a;
         b_sh   <= io.b;
         borrow <= io.b_in;
         count  <= '0;
         res    <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         res    <= res_nxt;
         borrow <= br;
         count  <= count + CW'(1);
         // Result outputs load only once, so they hold steady through DONE.
         if (last_slice) begin
            b_out_q <= br;
`ifdef SEQ_SUB_SAT_EN
            if (br) begin
               diff_q <= '0;
               zero_q <= 1'b1;
            end else begin
               diff_q <= res_nxt;
               zero_q <= (res_nxt == '0);
            end
`else
            diff_q <= res_nxt;
            zero_q <= (res_nxt == '0);
`endif
         end
      end
   end

   assign io.diff  = diff_q;
   assign io.b_out = b_out_q;
   assign io.zero  = zero_q;
endmodule

// File: tb/tb_seq_subtractor.sv
// Directed and randomized bench for seq_subtractor: 16/4 main instance plus
// 16/1, 16/16 and 32/8 instances for the parameter sweep.
module tb_seq_subtractor;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_subtractor_if #(.WIDTH(16)) m_if ();
   seq_subtractor_if #(.WIDTH(16)) d1_if ();
   seq_subtractor_if #(.WIDTH(16)) d16_if ();
   seq_subtractor_if #(.WIDTH(32)) w32_if ();

   seq_subtractor #(.WIDTH(16), .DIGIT(4))  u_dut (.clk(clk), .rst(rst), .io(m_if.slave));
   seq_subtractor #(.WIDTH(16), .DIGIT(1))  u_d1  (.clk(clk), .rst(rst), .io(d1_if.slave));
   seq_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (.clk(clk), .rst(rst), .io(d16_if.slave));
   seq_subtractor #(.WIDTH(32), .DIGIT(8))  u_w32 (.clk(clk), .rst(rst), .io(w32_if.slave));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] diff;
      logic        bout;
      logic        zero;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Saturating build: an underflowing result reads as zero.
   function automatic vec_t sat_adj(input vec_t v);
      vec_t r;
      r = v;
`ifdef SEQ_SUB_SAT_EN
      if (r.bout) begin
         r.diff = '0;
         r.zero = 1'b1;
      end
`endif
      return r;
   endfunction

   // Whole-word reference: {b_out, diff} = a - b - b_in on w bits.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic bin, input int w);
      logic [32:0] full;
      logic [31:0] mask;
      logic [31:0] dv;
      logic        bo;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      full = {1'b0, a & mask} - {1'b0, b & mask} - 33'(bin);
      bo   = full[w];
      dv   = full[31:0] & mask;
`ifdef SEQ_SUB_SAT_EN
      if (bo) dv = '0;
`endif
      return {bo, dv};
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input bit release_result, output int lat,
                         output logic [15:0] diff, output logic bo, output logic zero);
      int guard;
      guard = 0;
      while (m_if.in_ready !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      check("op_in_ready", 64'(m_if.in_ready), 64'(1));
      m_if.a        = a;
      m_if.b        = b;
      m_if.b_in     = bin;
      m_if.in_valid = 1'b1;
      tick();
      m_if.in_valid = 1'b0;
      lat = 0;
      while (m_if.out_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      check("op_ready_low_in_done", 64'(m_if.in_ready), 64'(0));
      diff = m_if.diff;
      bo   = m_if.b_out;
      zero = m_if.zero;
      if (release_result) begin
         m_if.out_ready = 1'b1;
         tick();
         m_if.out_ready = 1'b0;
      end
   endtask

   initial begin
      int          lat, l1, l16, l32, cyc;
      logic [15:0] dv;
      logic        bo, zr, seen;
      logic [31:0] ra, rb;
      logic        rbin;
      logic [32:0] m16, m32;
      vec_t        v;

      vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[3] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1};
      vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
      vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h0E1E, 1'b0, 1'b0};

      m_if.in_valid = 1'b0; m_if.out_ready = 1'b0; m_if.a = '0; m_if.b = '0; m_if.b_in = 1'b0;
      d1_if.in_valid = 1'b0; d1_if.out_ready = 1'b0; d1_if.a = '0; d1_if.b = '0; d1_if.b_in = 1'b0;
      d16_if.in_valid = 1'b0; d16_if.out_ready = 1'b0; d16_if.a = '0; d16_if.b = '0; d16_if.b_in = 1'b0;
      w32_if.in_valid = 1'b0; w32_if.out_ready = 1'b0; w32_if.a = '0; w32_if.b = '0; w32_if.b_in = 1'b0;

      // Reset held with a valid operand present must accept nothing.
      rst = 1'b1;
      m_if.in_valid = 1'b1;
      m_if.a = 16'h1234;
      m_if.b = 16'h0001;
      repeat (3) tick();
      rst = 1'b0;
      m_if.in_valid = 1'b0;
      check("rst_in_ready", 64'(m_if.in_ready), 64'(1));
      check("rst_out_valid", 64'(m_if.out_valid), 64'(0));
      check("rst_diff", 64'(m_if.diff), 64'(0));
      check("rst_b_out", 64'(m_if.b_out), 64'(0));
      check("rst_zero", 64'(m_if.zero), 64'(0));
      seen = 1'b0;
      repeat (6) begin
         tick();
         if (m_if.out_valid === 1'b1) seen = 1'b1;
      end
      check("rst_no_accept", 64'(seen), 64'(0));

      for (int i = 0; i < 8; i++) begin
         v = sat_adj(vecs[i]);
         run_op(v.a, v.b, v.bin, 1'b1, lat, dv, bo, zr);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
         check($sformatf("vec%0d_diff", i), 64'(dv), 64'(v.diff));
         check($sformatf("vec%0d_b_out", i), 64'(bo), 64'(v.bout));
         check($sformatf("vec%0d_zero", i), 64'(zr), 64'(v.zero));
         check($sformatf("vec%0d_released", i), 64'(m_if.out_valid), 64'(0));
      end

      // Backpressure: result held in DONE while new operands are offered.
      run_op(16'h1234, 16'h0234, 1'b0, 1'b0, lat, dv, bo, zr);
      check("bp_latency", 64'(lat), 64'(4));
      m_if.a = 16'hFFFF;
      m_if.b = 16'h0001;
      m_if.b_in = 1'b0;
      m_if.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_out_valid", 64'(m_if.out_valid), 64'(1));
         check("bp_in_ready", 64'(m_if.in_ready), 64'(0));
         check("bp_diff", 64'(m_if.diff), 64'(16'h1000));
         check("bp_b_out", 64'(m_if.b_out), 64'(0));
         check("bp_zero", 64'(m_if.zero), 64'(0));
      end
      m_if.in_valid = 1'b0;
      m_if.out_ready = 1'b1;
      tick();
      m_if.out_ready = 1'b0;
      check("bp_release_valid", 64'(m_if.out_valid), 64'(0));
      check("bp_release_ready", 64'(m_if.in_ready), 64'(1));
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, lat, dv, bo, zr);
      check("bp_next_diff", 64'(dv), 64'(16'hFFFE));
      check("bp_next_latency", 64'(lat), 64'(4));

      // Reset during the second RUN cycle discards the operation.
      m_if.a = 16'hAAAA;
      m_if.b = 16'h1111;
      m_if.b_in = 1'b0;
      m_if.in_valid = 1'b1;
      tick();
      m_if.in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_out_valid", 64'(m_if.out_valid), 64'(0));
      check("abort_in_ready", 64'(m_if.in_ready), 64'(1));
      check("abort_diff", 64'(m_if.diff), 64'(0));
      check("abort_b_out", 64'(m_if.b_out), 64'(0));
      check("abort_zero", 64'(m_if.zero), 64'(0));
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (m_if.out_valid === 1'b1) seen = 1'b1;
      end
      check("abort_never_valid", 64'(seen), 64'(0));
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, dv, bo, zr);
      check("abort_next_diff", 64'(dv), 64'(16'h7FFF));
      check("abort_next_b_out", 64'(bo), 64'(0));
      check("abort_next_latency", 64'(lat), 64'(4));

      // Parameter sweep: three widths/digits run side by side on shared operands.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 16 == 0) rb = ra;
         if (i % 50 == 1) ra = '0;
         rbin = 1'($urandom_range(0, 1));
         check("sw_in_ready", 64'({d1_if.in_ready, d16_if.in_ready, w32_if.in_ready}), 64'(3'b111));
         d1_if.a = ra[15:0];  d1_if.b = rb[15:0];  d1_if.b_in = rbin;  d1_if.in_valid = 1'b1;
         d16_if.a = ra[15:0]; d16_if.b = rb[15:0]; d16_if.b_in = rbin; d16_if.in_valid = 1'b1;
         w32_if.a = ra;       w32_if.b = rb;       w32_if.b_in = rbin; w32_if.in_valid = 1'b1;
         tick();
         d1_if.in_valid = 1'b0;
         d16_if.in_valid = 1'b0;
         w32_if.in_valid = 1'b0;
         l1 = -1; l16 = -1; l32 = -1; cyc = 0;
         while ((l1 < 0 || l16 < 0 || l32 < 0) && cyc < 100) begin
            tick();
            cyc++;
            if (l1 < 0 && d1_if.out_valid === 1'b1) l1 = cyc;
            if (l16 < 0 && d16_if.out_valid === 1'b1) l16 = cyc;
            if (l32 < 0 && w32_if.out_valid === 1'b1) l32 = cyc;
         end
         m16 = model(ra, rb, rbin, 16);
         m32 = model(ra, rb, rbin, 32);
         check("sw_d1_latency", 64'(l1), 64'(16));
         check("sw_d1_diff", 64'(d1_if.diff), 64'(m16[15:0]));
         check("sw_d1_b_out", 64'(d1_if.b_out), 64'(m16[32]));
         check("sw_d1_zero", 64'(d1_if.zero), 64'(m16[15:0] == 16'h0));
         check("sw_d16_latency", 64'(l16), 64'(1));
         check("sw_d16_diff", 64'(d16_if.diff), 64'(m16[15:0]));
         check("sw_d16_b_out", 64'(d16_if.b_out), 64'(m16[32]));
         check("sw_d16_zero", 64'(d16_if.zero), 64'(m16[15:0] == 16'h0));
         check("sw_w32_latency", 64'(l32), 64'(4));
         check("sw_w32_diff", 64'(w32_if.diff), 64'(m32[31:0]));
         check("sw_w32_b_out", 64'(w32_if.b_out), 64'(m32[32]));
         check("sw_w32_zero", 64'(w32_if.zero), 64'(m32[31:0] == 32'h0));
         d1_if.out_ready = 1'b1;
         d16_if.out_ready = 1'b1;
         w32_if.out_ready = 1'b1;
         tick();
         d1_if.out_ready = 1'b0;
         d16_if.out_ready = 1'b0;
         w32_if.out_ready = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
